imem_line_resp: RTL and testbench
=================================

IMEM_LINE_RESP -- requirements
Module: imem_line_resp

Interface
REQ-001 SHALL have parameter ACCESS_LAT, default 4, meaning added wait cycles per line read, legal range 0..15.
REQ-002 SHALL have parameter ROM_AW, default 14, meaning the word-address width of the backing instruction ROM.
REQ-003 SHALL have port cpu_clk  input  1  meaning the single clock; all logic is rising-edge.
REQ-004 SHALL have port cpu_rst_n  input  1  meaning reset, asynchronous and active-low.
REQ-005 SHALL have port mem_rrdy  output  1  meaning the responder can accept a read request.
REQ-006 SHALL have port mem_ren  input  4  meaning read enable from the cache; a nonzero value is a request.
REQ-007 SHALL have port mem_raddr  input  32  meaning the byte address of the request.
REQ-008 SHALL have port mem_rvalid  output  1  meaning mem_rdata holds the requested line.
REQ-009 SHALL have port mem_rdata  output  128  meaning the returned 4-word line.
REQ-010 SHALL have port rom_addr  output  ROM_AW  meaning the word address to the synchronous ROM.
REQ-011 SHALL have port rom_dout  input  32  meaning ROM data, valid one cycle after rom_addr.
REQ-012 SHALL have port served_cnt  output  32  meaning the count of completed line responses.

Function
REQ-013 SHALL implement states IDLE, WAIT, FETCH and RESP.
REQ-014 SHALL accept a request only on an edge where state is IDLE, mem_rrdy=1 and mem_ren!=0, capturing base = mem_raddr[ROM_AW+1:2].
REQ-015 SHALL ignore mem_ren and mem_raddr in every other state, including the RESP cycle.
REQ-016 SHALL, on acceptance, go IDLE->WAIT when ACCESS_LAT>0 and IDLE->FETCH when ACCESS_LAT=0.
REQ-017 SHALL stay in WAIT for exactly ACCESS_LAT cycles (down-counter), then go to FETCH.
REQ-018 SHALL spend 5 cycles in FETCH: cycles k=0..3 drive rom_addr=base+k modulo 2^ROM_AW; cycles 1..4 capture rom_dout into word k-1.
REQ-019 SHALL place word i in mem_rdata[32i+31:32i]; addresses are not realigned, so an unaligned base yields base..base+3.
REQ-020 SHALL drive rom_addr to 0 outside FETCH.
REQ-021 SHALL assert mem_rvalid, registered, for exactly one cycle (RESP), starting at the (ACCESS_LAT+5)th rising edge after the accepting edge (accepting edge = 0).
REQ-022 SHALL keep mem_rdata stable from the RESP cycle until the next response overwrites it.
REQ-023 SHALL go RESP->IDLE and raise mem_rrdy at the edge ending RESP; mem_rrdy SHALL be 1 only in IDLE.
REQ-024 SHALL increment served_cnt by 1 at the edge entering RESP, wrapping from 0xFFFFFFFF to 0.
REQ-025 SHALL treat mem_ren held high across the response as a new request at the first IDLE edge.

Reset
REQ-026 SHALL force the following when cpu_rst_n=0, asynchronously: state IDLE, mem_rrdy 0, mem_rvalid 0, mem_rdata 0, served_cnt 0, counters 0, rom_addr 0.
REQ-027 SHALL raise mem_rrdy at the first rising edge after cpu_rst_n deasserts.
REQ-028 SHALL abort an in-flight request when reset asserts mid-operation, producing no response and no served_cnt increment.

Structure
REQ-029 SHALL take BLK_LEN=4, BLK_SIZE=128 and the 2-bit state encoding from shared package ibus_pkg, which the cache side also uses.
REQ-030 SHALL instantiate one sub-module, imem_line_asm: a 4x32 word-capture register with write index and write enable, producing the 128-bit line.
REQ-031 SHALL be 120-400 lines of RTL with no latches; the next-state logic SHALL be combinational with a default of IDLE.

Verification
REQ-032 SHALL cover: ACCESS_LAT=4, ROM word n = 0x1000_0000+n, request mem_raddr=0x40, mem_ren=4'hF -> mem_rvalid high 1 cycle at edge 9, mem_rdata=0x10000013_10000012_10000011_10000010.
REQ-033 SHALL cover: ACCESS_LAT=0, mem_raddr=0x44 (unaligned) -> mem_rvalid at edge 5, words 0x11,0x12,0x13,0x14 in ascending lanes.
REQ-034 SHALL cover: ROM_AW=14, mem_raddr=0xFFF8 -> rom_addr sequence 0x3FFE, 0x3FFF, 0x0000, 0x0001.
REQ-035 SHALL cover: mem_ren pulsed while in WAIT and again in RESP -> ignored; exactly one response; served_cnt=1.
REQ-036 SHALL cover: cpu_rst_n low for 1 cycle during FETCH -> mem_rvalid never asserts, served_cnt=0, mem_rrdy=1 after the first edge following release.
REQ-037 SHALL cover: back-to-back requests with mem_ren held at 4'hF -> responses spaced ACCESS_LAT+7 cycles apart, served_cnt increments on each.

Source files
------------

// File: rtl/ibus_pkg.sv
// ibus_pkg: line geometry and responder state encoding shared by the
// instruction cache and its line responder.
package ibus_pkg;
   localparam int BLK_LEN  = 4;
   localparam int WORD_W   = 32;
   localparam int BLK_SIZE = BLK_LEN * WORD_W;
   localparam int IDX_W    = $clog2(BLK_LEN);
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      FETCH = 2'd2,
      RESP  = 2'd3
   } ibus_state_e;
endpackage

// File: rtl/imem_line_asm.sv
// imem_line_asm: collects ROM words into a line; the published line only
// updates when the last word lands, so it holds between responses.
module imem_line_asm
   import ibus_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                we,
   input  logic [IDX_W-1:0]    idx,
   input  logic [WORD_W-1:0]   din,
   output logic [BLK_SIZE-1:0] line
);
   logic [BLK_SIZE-1:0] words, nxt;
   always_comb begin
      nxt = words;
      if (we) nxt[WORD_W*idx +: WORD_W] = din;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         words <= '0;
         line  <= '0;
      end else begin
         words <= nxt;
         line  <= (we && idx == IDX_W'(BLK_LEN - 1)) ? nxt : line;
      end
endmodule

// File: rtl/imem_line_resp.sv
// imem_line_resp: answers cache line reads by streaming four words out of a
// synchronous instruction ROM after a fixed access latency.
module imem_line_resp
   import ibus_pkg::*;
#(
   parameter int ACCESS_LAT = 4,
   parameter int ROM_AW     = 14
) (
   input  logic                cpu_clk,
   input  logic                cpu_rst_n,
   output logic                mem_rrdy,
   input  logic [3:0]          mem_ren,
   input  logic [31:0]         mem_raddr,
   output logic                mem_rvalid,
   output logic [BLK_SIZE-1:0] mem_rdata,
   output logic [ROM_AW-1:0]   rom_addr,
   input  logic [31:0]         rom_dout,
   output logic [31:0]         served_cnt
);
   localparam int WAIT_INIT = (ACCESS_LAT > 0) ? ACCESS_LAT - 1 : 0;
   ibus_state_e state, nxt;
   logic [ROM_AW-1:0] base;
   logic [3:0] wcnt;
   logic [2:0] fcnt;
   logic accept, cap_we, unused;
   assign unused   = ^{mem_raddr[31:ROM_AW+2], mem_raddr[1:0]};
   assign accept   = (state == IDLE) && mem_rrdy && (mem_ren != 4'd0);
   // ROM data lags its address by one cycle, so capture trails fetch by one
   assign cap_we   = (state == FETCH) && (fcnt != 3'd0);
   assign rom_addr = (state == FETCH && fcnt < 3'(BLK_LEN)) ? base + ROM_AW'(fcnt) : '0;
   always_comb begin
      nxt = IDLE;
      case (state)
         IDLE:    nxt = accept ? ((ACCESS_LAT == 0) ? FETCH : WAIT) : IDLE;
         WAIT:    nxt = (wcnt == 4'd0) ? FETCH : WAIT;
         FETCH:   nxt = (fcnt == 3'(BLK_LEN)) ? RESP : FETCH;
         default: nxt = IDLE;
      endcase
   end
   always_ff @(posedge cpu_clk or negedge cpu_rst_n)
      if (!cpu_rst_n) begin
         state      <= IDLE;
         mem_rrdy   <= 1'b0;
         mem_rvalid <= 1'b0;
         served_cnt <= '0;
         base       <= '0;
         wcnt       <= '0;
         fcnt       <= '0;
      end else begin
         state      <= nxt;
         mem_rrdy   <= (nxt == IDLE);
         mem_rvalid <= (nxt == RESP);
         served_cnt <= (nxt == RESP) ? served_cnt + 32'd1 : served_cnt;
         base       <= accept ? mem_raddr[ROM_AW+1:2] : base;
         wcnt       <= accept ? 4'(WAIT_INIT) : (state == WAIT && wcnt != 4'd0) ? wcnt - 4'd1 : wcnt;
         fcnt       <= (state == FETCH && fcnt != 3'(BLK_LEN)) ? fcnt + 3'd1 : 3'd0;
      end
   imem_line_asm u_asm (
      .clk   (cpu_clk),
      .rst_n (cpu_rst_n),
      .we    (cap_we),
      .idx   (IDX_W'(fcnt - 3'd1)),
      .din   (rom_dout),
      .line  (mem_rdata)
   );
endmodule

// File: tb/tb_imem_line_resp.sv
// tb_imem_line_resp: directed checks of the line responder at two access
// latencies, each backed by a ROM whose word n reads 0x1000_0000+n.
module tb_imem_line_resp;
   typedef struct {
      logic         sel;
      logic [31:0]  addr;
      int           exp_lat;
      logic [13:0]  rom0;
      logic [127:0] rdata;
   } vec_t;

   logic clk = 1'b0, rst_n = 1'b0;
   logic a_rrdy, a_rvalid, b_rrdy, b_rvalid;
   logic [3:0] a_ren = 4'h0, b_ren = 4'h0;
   logic [31:0] a_raddr = 32'h0, b_raddr = 32'h0;
   logic [31:0] a_rom_dout, b_rom_dout, a_served, b_served;
   logic [127:0] a_rdata, b_rdata;
   logic [13:0] a_rom_addr, b_rom_addr;
   int cyc = 0, n_chk = 0, n_fail = 0;
   int exp_cnt [2] = '{0, 0};
   vec_t tbl [6];

   imem_line_resp #(.ACCESS_LAT(4), .ROM_AW(14)) u_lat4 (
      .cpu_clk(clk), .cpu_rst_n(rst_n), .mem_rrdy(a_rrdy), .mem_ren(a_ren),
      .mem_raddr(a_raddr), .mem_rvalid(a_rvalid), .mem_rdata(a_rdata),
      .rom_addr(a_rom_addr), .rom_dout(a_rom_dout), .served_cnt(a_served));
   imem_line_resp #(.ACCESS_LAT(0), .ROM_AW(14)) u_lat0 (
      .cpu_clk(clk), .cpu_rst_n(rst_n), .mem_rrdy(b_rrdy), .mem_ren(b_ren),
      .mem_raddr(b_raddr), .mem_rvalid(b_rvalid), .mem_rdata(b_rdata),
      .rom_addr(b_rom_addr), .rom_dout(b_rom_dout), .served_cnt(b_served));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) a_rom_dout <= 32'h1000_0000 + 32'(a_rom_addr);
   always @(posedge clk) b_rom_dout <= 32'h1000_0000 + 32'(b_rom_addr);

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, time %0t required below 2000000", $time);
      $fatal(1);
   end

   function automatic logic rv(input logic s);
      return s ? b_rvalid : a_rvalid;
   endfunction
   function automatic logic rr(input logic s);
      return s ? b_rrdy : a_rrdy;
   endfunction
   function automatic logic [127:0] rd(input logic s);
      return s ? b_rdata : a_rdata;
   endfunction
   function automatic logic [31:0] sc(input logic s);
      return s ? b_served : a_served;
   endfunction
   function automatic logic [13:0] ra(input logic s);
      return s ? b_rom_addr : a_rom_addr;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic set_req(input logic s, input logic [3:0] ren, input logic [31:0] addr);
      if (s) begin
         b_ren = ren;
         b_raddr = addr;
      end else begin
         a_ren = ren;
         a_raddr = addr;
      end
   endtask

   task automatic wait_rdy(input logic s);
      int k = 0;
      while (!rr(s) && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("rrdy_wait", 128'(rr(s)), 128'(1));
   endtask

   task automatic run_vec(input vec_t v);
      int start, got, lat;
      logic [13:0] ea;
      lat = v.exp_lat - 5;
      wait_rdy(v.sel);
      set_req(v.sel, 4'hF, v.addr);
      start = cyc + 1;
      @(negedge clk);
      set_req(v.sel, 4'h0, 32'h0);
      got = -1;
      for (int k = 0; k < 40; k++) begin
         ea = (k >= lat && k < lat + 4) ? v.rom0 + 14'(k - lat) : 14'h0;
         chk("rom_addr", 128'(ra(v.sel)), 128'(ea));
         @(negedge clk);
         if (rv(v.sel)) begin
            got = cyc - start;
            break;
         end
      end
      exp_cnt[v.sel]++;
      chk("latency", 128'(got), 128'(v.exp_lat));
      chk("rdata", rd(v.sel), v.rdata);
      chk("served_cnt", 128'(sc(v.sel)), 128'(exp_cnt[v.sel]));
      @(negedge clk);
      chk("rvalid_one_cycle", 128'(rv(v.sel)), 128'(0));
      chk("rrdy_after_resp", 128'(rr(v.sel)), 128'(1));
      chk("rdata_hold", rd(v.sel), v.rdata);
   endtask

   task automatic b2b(input logic s, input int exp_first, input int exp_gap, input logic [127:0] exp_rd);
      int t [3] = '{0, 0, 0};
      int n = 0;
      int start;
      wait_rdy(s);
      set_req(s, 4'hF, 32'h40);
      start = cyc + 1;
      for (int k = 0; k < 200 && n < 3; k++) begin
         @(negedge clk);
         if (rv(s)) begin
            t[n] = cyc;
            n++;
            exp_cnt[s]++;
            chk("b2b_served", 128'(sc(s)), 128'(exp_cnt[s]));
            chk("b2b_rdata", rd(s), exp_rd);
         end
      end
      set_req(s, 4'h0, 32'h0);
      chk("b2b_count", 128'(n), 128'(3));
      chk("b2b_first", 128'(t[0] - start), 128'(exp_first));
      chk("b2b_gap1", 128'(t[1] - t[0]), 128'(exp_gap));
      chk("b2b_gap2", 128'(t[2] - t[1]), 128'(exp_gap));
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int start, got, pulses;
      tbl[0] = '{sel: 1'b0, addr: 32'h0000_0040, exp_lat: 9, rom0: 14'h0010,
                 rdata: 128'h10000013_10000012_10000011_10000010};
      tbl[1] = '{sel: 1'b1, addr: 32'h0000_0044, exp_lat: 5, rom0: 14'h0011,
                 rdata: 128'h10000014_10000013_10000012_10000011};
      tbl[2] = '{sel: 1'b0, addr: 32'h0000_FFF8, exp_lat: 9, rom0: 14'h3FFE,
                 rdata: 128'h10000001_10000000_10003FFF_10003FFE};
      tbl[3] = '{sel: 1'b1, addr: 32'h0000_0FFC, exp_lat: 5, rom0: 14'h03FF,
                 rdata: 128'h10000402_10000401_10000400_100003FF};
      tbl[4] = '{sel: 1'b0, addr: 32'hABCD_0003, exp_lat: 9, rom0: 14'h0000,
                 rdata: 128'h10000003_10000002_10000001_10000000};
      tbl[5] = '{sel: 1'b1, addr: 32'h0000_FFF8, exp_lat: 5, rom0: 14'h3FFE,
                 rdata: 128'h10000001_10000000_10003FFF_10003FFE};

      repeat (2) @(negedge clk);
      chk("rst_rrdy", 128'(a_rrdy), 128'(0));
      chk("rst_rvalid", 128'(a_rvalid), 128'(0));
      chk("rst_rdata", a_rdata, 128'(0));
      chk("rst_served", 128'(a_served), 128'(0));
      chk("rst_rom_addr", 128'(a_rom_addr), 128'(0));
      chk("rst_rrdy_b", 128'(b_rrdy), 128'(0));
      rst_n = 1'b1;
      #1;
      chk("rrdy_before_edge", 128'(a_rrdy), 128'(0));
      @(negedge clk);
      chk("rrdy_after_release", 128'(a_rrdy), 128'(1));
      chk("rrdy_after_release_b", 128'(b_rrdy), 128'(1));

      foreach (tbl[i]) run_vec(tbl[i]);

      wait_rdy(1'b0);
      set_req(1'b0, 4'hF, 32'h80);
      start = cyc + 1;
      @(negedge clk);
      set_req(1'b0, 4'h0, 32'h0);
      repeat (2) @(negedge clk);
      set_req(1'b0, 4'hF, 32'h200);
      @(negedge clk);
      set_req(1'b0, 4'h0, 32'h0);
      got = -1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (a_rvalid) begin
            got = cyc - start;
            break;
         end
      end
      chk("ignore_latency", 128'(got), 128'(9));
      set_req(1'b0, 4'hF, 32'h300);
      @(negedge clk);
      set_req(1'b0, 4'h0, 32'h0);
      pulses = 0;
      repeat (30) begin
         if (a_rvalid) pulses++;
         @(negedge clk);
      end
      exp_cnt[0]++;
      chk("ignore_pulses", 128'(pulses), 128'(0));
      chk("ignore_served", 128'(a_served), 128'(exp_cnt[0]));
      chk("ignore_rdata", a_rdata, 128'h10000023_10000022_10000021_10000020);

      b2b(1'b0, 9, 11, 128'h10000013_10000012_10000011_10000010);
      b2b(1'b1, 5, 7, 128'h10000013_10000012_10000011_10000010);

      wait_rdy(1'b0);
      set_req(1'b0, 4'hF, 32'h40);
      @(negedge clk);
      set_req(1'b0, 4'h0, 32'h0);
      repeat (5) @(negedge clk);
      chk("abort_in_fetch", 128'(a_rom_addr), 128'(14'h0011));
      rst_n = 1'b0;
      #1;
      chk("abort_rvalid", 128'(a_rvalid), 128'(0));
      chk("abort_rrdy", 128'(a_rrdy), 128'(0));
      chk("abort_rom_addr", 128'(a_rom_addr), 128'(0));
      chk("abort_served", 128'(a_served), 128'(0));
      chk("abort_rdata", a_rdata, 128'(0));
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("abort_rrdy_pre_edge", 128'(a_rrdy), 128'(0));
      @(negedge clk);
      chk("abort_rrdy_post_edge", 128'(a_rrdy), 128'(1));
      pulses = 0;
      repeat (20) begin
         if (a_rvalid) pulses++;
         @(negedge clk);
      end
      chk("abort_no_resp", 128'(pulses), 128'(0));
      chk("abort_served_zero", 128'(a_served), 128'(0));
      exp_cnt[0] = 0;
      exp_cnt[1] = 0;
      run_vec(tbl[0]);
      run_vec(tbl[1]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
